fpu_issue_ctrl: RTL and testbench

- Issue side of the ALU/FPU result path in the EX stage; the counterpart of the final result select.
- Decodes i_alu_op, recognises the four FP opcodes (5'b01010..5'b01101), and latches operands.
- Hands the operation to the multi-cycle FPU over a req/ack/done handshake.
- Stalls the pipeline until the FPU result is captured, then presents that result for one cycle to the result select.

---
 rtl/fpu_issue_ctrl.sv | 137 +++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
// EX-stage issue controller for the multi-cycle FPU: decodes FP ops, latches
// operands, runs the req/ack/done handshake and stalls until the result is captured.
module fpu_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_flush,
  input  logic [4:0]  i_alu_op,
  input  logic [31:0] i_operand_a,
  input  logic [31:0] i_operand_b,
  output logic        o_stall,
  output logic        o_fpu_req,
  output logic [1:0]  o_fpu_op,
  output logic [31:0] o_fpu_a,
  output logic [31:0] o_fpu_b,
  input  logic        i_fpu_ack,
  input  logic        i_fpu_done,
  input  logic [31:0] i_fpu_data,
  output logic [31:0] o_fpu_result,
  output logic        o_result_valid,
  output logic        o_fpu_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [1:0]        op_q, op_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [31:0]       result_q, result_d;
  logic              err_q, err_d;
  logic              fp_hit, tmo, busy;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    err_d    = 1'b0;

    fp_hit  = i_valid & ~i_flush & (i_alu_op inside {[5'b01010:5'b01101]});
    cnt_inc = cnt_q + CNT_W'(1);
    tmo     = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
    busy    = (state_q == S_REQ) || (state_q == S_WAIT);

    case (state_q)
      S_IDLE: begin
        if (fp_hit) begin
          a_d     = i_operand_a;
          b_d     = i_operand_b;
          // 01010..01101 map to 0..3 by flipping bit 1 of the low pair
          op_d    = i_alu_op[1:0] ^ 2'b10;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc;
        if (i_flush) begin
          state_d = (i_fpu_ack && !i_fpu_done) ? S_DRAIN : S_IDLE;
        end else if (i_fpu_ack && i_fpu_done) begin
          result_d = i_fpu_data;
          state_d  = S_DONE;
        end else if (i_fpu_ack) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (i_fpu_done) begin
          if (i_flush) begin
            state_d = S_IDLE;
          end else begin
            result_d = i_fpu_data;
            state_d  = S_DONE;
          end
        end else if (i_flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_DRAIN: begin
        cnt_d = cnt_inc;
        if (i_fpu_done || tmo) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Timeout only forces completion when the transaction would otherwise stay open
    if (busy && tmo && ((state_d == S_REQ) || (state_d == S_WAIT))) begin
      result_d = '0;
      err_d    = 1'b1;
      state_d  = S_DONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign o_stall        = (((state_q == S_IDLE) || (state_q == S_DRAIN)) && fp_hit) || busy;
  assign o_fpu_req      = (state_q == S_REQ);
  assign o_fpu_op       = op_q;
  assign o_fpu_a        = a_q;
  assign o_fpu_b        = b_q;
  assign o_fpu_result   = result_q;
  assign o_result_valid = (state_q == S_DONE);
  assign o_fpu_err      = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: issue/capture, non-FP, back-to-back,
// flush-to-drain, timeout and mid-transaction reset.
module tb_fpu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, flush, ack, done;
  logic [4:0]  alu_op;
  logic [31:0] opa, opb, fdata;
  logic        stall, req, rv, err;
  logic [1:0]  fop;
  logic [31:0] fa, fb, fres;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(7)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_valid       (valid),
    .i_flush       (flush),
    .i_alu_op      (alu_op),
    .i_operand_a   (opa),
    .i_operand_b   (opb),
    .o_stall       (stall),
    .o_fpu_req     (req),
    .o_fpu_op      (fop),
    .o_fpu_a       (fa),
    .o_fpu_b       (fb),
    .i_fpu_ack     (ack),
    .i_fpu_done    (done),
    .i_fpu_data    (fdata),
    .o_fpu_result  (fres),
    .o_result_valid(rv),
    .o_fpu_err     (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge; inputs are driven here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // let combinational outputs settle before sampling
  task automatic settle();
    #2;
  endtask

  task automatic chk_ctl(input string tag, input logic s, input logic r, input logic v, input logic e);
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, s});
    chk({tag, ".req"},   {31'd0, req},   {31'd0, r});
    chk({tag, ".rv"},    {31'd0, rv},    {31'd0, v});
    chk({tag, ".err"},   {31'd0, err},   {31'd0, e});
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; flush = 1'b0; ack = 1'b0; done = 1'b0;
    alu_op = 5'b00000; opa = '0; opb = '0; fdata = '0;
    #2;
    chk_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.op", {30'd0, fop}, 32'd0);
    chk("rst.a", fa, 32'd0);
    chk("rst.b", fb, 32'd0);
    chk("rst.res", fres, 32'd0);
    #10 rst_n = 1'b1;

    // issue and capture: ack one cycle after req, done three cycles after ack
    tick();
    valid = 1'b1; alu_op = 5'b01010; opa = 32'h3F800000; opb = 32'h40000000;
    settle(); chk_ctl("t1.issue", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); settle();
    chk_ctl("t1.req0", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1.op", {30'd0, fop}, 32'd0);
    chk("t1.a", fa, 32'h3F800000);
    chk("t1.b", fb, 32'h40000000);
    tick(); ack = 1'b1;
    settle(); chk_ctl("t1.ack", 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); ack = 1'b0;
    settle(); chk_ctl("t1.wait1", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); settle(); chk_ctl("t1.wait2", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); done = 1'b1; fdata = 32'h40400000;
    settle(); chk_ctl("t1.done", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); done = 1'b0; fdata = '0;
    settle(); chk_ctl("t1.dst", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1.res", fres, 32'h40400000);
    tick(); valid = 1'b0;
    settle(); chk_ctl("t1.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1.hold", fres, 32'h40400000);

    // non-FP op never stalls or requests
    valid = 1'b1; alu_op = 5'b00000;
    for (int i = 0; i < 10; i++) begin
      tick(); settle();
      chk_ctl("t2.nonfp", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // back-to-back with ack+done in the same cycle
    tick(); alu_op = 5'b01100;
    settle(); chk_ctl("t3.iss1", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); ack = 1'b1; done = 1'b1; fdata = 32'h11111111;
    settle(); chk_ctl("t3.req1", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t3.op1", {30'd0, fop}, 32'd2);
    tick(); ack = 1'b0; done = 1'b0; alu_op = 5'b01101;
    settle(); chk_ctl("t3.done1", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3.res1", fres, 32'h11111111);
    tick(); settle(); chk_ctl("t3.iss2", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); ack = 1'b1; done = 1'b1; fdata = 32'h22222222;
    settle(); chk_ctl("t3.req2", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t3.op2", {30'd0, fop}, 32'd3);
    tick(); ack = 1'b0; done = 1'b0; valid = 1'b0;
    settle(); chk_ctl("t3.done2", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3.res2", fres, 32'h22222222);
    tick(); settle(); chk_ctl("t3.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // flush in WAIT, then drain the killed transaction's done
    valid = 1'b1; alu_op = 5'b01011; opa = 32'd1; opb = 32'd2;
    settle(); chk_ctl("t4.iss", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); ack = 1'b1;
    settle(); chk("t4.op", {30'd0, fop}, 32'd1);
    tick(); ack = 1'b0; flush = 1'b1;
    settle(); chk_ctl("t4.flush", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); flush = 1'b0; valid = 1'b0;
    settle(); chk_ctl("t4.drain0", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); valid = 1'b1; alu_op = 5'b01010;
    settle(); chk_ctl("t4.drainfp", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); valid = 1'b0;
    settle(); chk_ctl("t4.drain2", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); done = 1'b1; fdata = 32'hDEADBEEF;
    settle(); chk_ctl("t4.ddone", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); done = 1'b0; fdata = '0;
    settle(); chk_ctl("t4.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4.res", fres, 32'h22222222);

    // timeout: ack given, done never arrives
    valid = 1'b1; alu_op = 5'b01101;
    tick(); ack = 1'b1;
    settle(); chk_ctl("t5.req", 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); ack = 1'b0;
    for (int i = 0; i < 7; i++) begin
      settle(); chk_ctl("t5.wait", 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    settle(); chk_ctl("t5.tmo", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5.res", fres, 32'd0);
    tick(); valid = 1'b0;
    settle(); chk_ctl("t5.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // asynchronous reset while in WAIT
    tick(); valid = 1'b1; alu_op = 5'b01010; opa = 32'hAAAA5555; opb = 32'h5555AAAA;
    tick(); ack = 1'b1;
    tick(); ack = 1'b0; fdata = 32'h0BADF00D;
    tick(); settle();
    chk_ctl("t6.wait", 1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0; valid = 1'b0;
    #1;
    chk_ctl("t6.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6.op", {30'd0, fop}, 32'd0);
    chk("t6.a", fa, 32'd0);
    chk("t6.b", fb, 32'd0);
    chk("t6.res", fres, 32'd0);
    #1 rst_n = 1'b1;
    tick(); done = 1'b1; fdata = 32'h12345678;
    settle(); chk_ctl("t6.late", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); done = 1'b0;
    settle(); chk_ctl("t6.after", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6.res2", fres, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
